// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default link constants, divider math.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

    // Default link settings, also used by the transmitter.
    localparam int DEF_CLK_FREQ = 125_000_000;
    localparam int DEF_BAUD     = 115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Restartable clock divider producing a one-cycle tick every DIV clocks.
// Latency: first tick DIV clocks after restart (counter runs 0..DIV-1, tick at DIV-1).
// Backpressure: none; free-running except when restart forces the count to zero.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV = calc_div(DEF_CLK_FREQ, DEF_BAUD, 16)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Wrap at DIV-1; restart realigns the tick phase to the detected start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling, byte output on a valid/ready handshake.
// Latency: rx_valid rises 3 clocks after the mid-stop-bit line value (2 sync + 1 register).
// Backpressure: one-byte holding register; a byte completing while it is full and not being
//   accepted is dropped with a one-cycle overrun pulse.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    uart_state_t          r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;
    logic                 r_wait_high;

    logic w_rxs;
    logic w_start;
    logic w_tick;

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs   = r_sync2;
    // After a framing error (e.g. break) a low line is not a new start until it has gone high.
    assign w_start = (r_state == IDLE) && !r_wait_high && !w_rxs;

    uart_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_start),
        .tick    (w_tick)
    );

    // Frame FSM with registered outputs: start qualify, data shift, stop check, delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
            r_wait_high <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer handshake; a delivery in the same cycle below overrides the clear.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_wait_high) begin
                        if (w_rxs) begin
                            r_wait_high <= 1'b0;
                        end
                    end else if (!w_rxs) begin
                        r_state    <= START;
                        r_busy     <= 1'b1;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end

                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TC_MID) begin
                            if (w_rxs) begin
                                // Low pulse shorter than half a bit: treat as noise.
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state    <= DATA;
                                r_tick_cnt <= '0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TC_LAST) begin
                            r_tick_cnt <= '0;
                            // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                            r_shift    <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == BC_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end

                STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TC_LAST) begin
                            // Leave at mid stop bit so a back-to-back start edge is not missed.
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_tick_cnt <= '0;
                            if (w_rxs) begin
                                if (!r_rx_valid || rx_ready) begin
                                    r_rx_data  <= r_shift;
                                    r_rx_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_wait_high <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: vector table, hand-written corner sequences, random frames.
// Latency: n/a.
// Backpressure: rx_ready driven by the bench.
module tb_uart_rx_core;

    // Clock frequency scaled so one bit is 128 clocks (DIV=8) to keep the run short.
    localparam int CLK_FREQ  = 14_745_600;
    localparam int BAUD      = 115_200;
    localparam int OS        = 16;
    localparam int DB        = 8;
    localparam int DIV_TB    = (CLK_FREQ + BAUD * OS / 2) / (BAUD * OS);
    localparam int BIT       = OS * DIV_TB;
    localparam int HALF      = BIT / 2;
    // Edges from the edge before the start drive to the stop-sample edge:
    // 2 sync + 1 start-detect, then OS/2 + OS*(DB+1) ticks of DIV clocks each.
    localparam int STOP_EDGE = 3 + (OS / 2 + OS * (DB + 1)) * DIV_TB;

    logic          clk;
    logic          rst_n;
    logic          rx_i;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int n_tests;
    int n_fail;

    logic [7:0] got_q[$];
    int         ferr_cnt;
    int         ovr_cnt;
    int         valid_cycles;
    int         valid_low;
    logic       busy_seen;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs on the falling edge; rx_ready only changes just after rising edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (busy) busy_seen = 1'b1;
            if (rx_valid) valid_cycles++;
            else valid_low++;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        valid_cycles = 0;
        valid_low    = 0;
        busy_seen    = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];
    int         exp_ferr;
    int         fall_at;
    logic [7:0] d;
    logic       ok;
    int         gap;
    int         nmin;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rx_i      = 1'b1;
        rx_ready  = 1'b0;
        rst_n     = 1'b0;
        clear_mon();

        // ---- reset state ----
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_flags", {27'd0, rx_valid, frame_err, overrun, busy, 1'b0}, 32'h0);
        rst_n = 1'b1;
        idle(4);

        // ---- table-driven single frames, consumer always ready ----
        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b1, 1, 0};
        vecs[2] = '{8'hA3, 1'b0, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 0};
        vecs[5] = '{8'h80, 1'b0, 0, 1};
        vecs[6] = '{8'h01, 1'b1, 1, 0};
        vecs[7] = '{8'hC3, 1'b1, 1, 0};
        rx_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].stop);
            idle(BIT);
            check($sformatf("vec%0d_count", v), got_q.size(), vecs[v].exp_n);
            if (got_q.size() > 0) check($sformatf("vec%0d_data", v), 32'(got_q[0]), 32'(vecs[v].data));
            check($sformatf("vec%0d_frame_err", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("vec%0d_overrun", v), ovr_cnt, 0);
            check($sformatf("vec%0d_valid_cycles", v), valid_cycles, vecs[v].exp_n);
            check($sformatf("vec%0d_busy_idle", v), 32'(busy), 32'h0);
        end

        // ---- busy falls about half a bit into the stop bit ----
        clear_mon();
        fall_at = -1;
        fork
            send_frame(8'h55, 1'b1);
            begin : meas
                int cyc;
                cyc = 0;
                while (!busy && cyc < 2 * BIT) begin @(posedge clk); #1; cyc++; end
                while (busy && cyc < 12 * BIT) begin @(posedge clk); #1; cyc++; end
                if (!busy) fall_at = cyc;
            end
        join
        idle(BIT);
        check("busy_fall_in_stop_window",
              32'((fall_at >= 9 * BIT + HALF) && (fall_at <= 9 * BIT + HALF + 6)), 32'h1);
        check("busy_frame_data", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF, 32'h55);

        // ---- short low glitch rejected, next frame fine ----
        clear_mon();
        rx_i = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        idle(2 * BIT);
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_no_byte", got_q.size(), 0);
        check("glitch_no_ferr", ferr_cnt, 0);
        send_frame(8'h3C, 1'b1);
        idle(BIT);
        check("post_glitch_data", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF, 32'h3C);

        // ---- back-to-back with consumer stalled: overrun on second byte ----
        rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(16);
        check("ovr_held_valid", 32'(rx_valid), 32'h1);
        check("ovr_held_data", 32'(rx_data), 32'h12);
        check("ovr_pulse_count", ovr_cnt, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_valid_drops", 32'(rx_valid), 32'h0);
        check("ovr_accepted", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF, 32'h12);
        idle(8);

        // ---- ready pulsed in exactly the cycle the next byte completes ----
        rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h12, 1'b1);
        idle(16);
        valid_low = 0;
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(16);
        check("same_cycle_data", 32'(rx_data), 32'h34);
        check("same_cycle_valid_kept", valid_low, 0);
        check("same_cycle_no_overrun", ovr_cnt, 0);
        check("same_cycle_old_accepted", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF, 32'h12);
        rx_ready = 1'b1;
        idle(8);

        // ---- break: one framing error, then wait for line high ----
        clear_mon();
        rx_i = 1'b0;
        repeat (12 * BIT) @(posedge clk);
        #1;
        check("break_ferr_once", ferr_cnt, 1);
        check("break_no_byte", got_q.size(), 0);
        check("break_idle_not_busy", 32'(busy), 32'h0);
        idle(BIT);
        send_frame(8'h5A, 1'b1);
        idle(BIT);
        check("post_break_data", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF, 32'h5A);
        check("post_break_ferr", ferr_cnt, 1);

        // ---- reset mid-frame with a byte held ----
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        idle(16);
        check("pre_reset_held", 32'(rx_valid), 32'h1);
        d = 8'hF0;
        rx_i = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx_i = d[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx_i = d[4];
        repeat (HALF) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {rx_data, 19'd0, rx_valid, frame_err, overrun, busy, 1'b0}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        rx_i  = 1'b1;
        rst_n = 1'b1;
        idle(8);
        rx_ready = 1'b1;
        clear_mon();
        send_frame(8'hC3, 1'b1);
        idle(BIT);
        check("post_reset_count", got_q.size(), 1);
        if (got_q.size() > 0) check("post_reset_data", 32'(got_q[0]), 32'hC3);
        check("post_reset_flags", ferr_cnt + ovr_cnt, 0);

        // ---- randomized frames against a queue model ----
        clear_mon();
        exp_q.delete();
        exp_ferr = 0;
        for (int k = 0; k < 24; k++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok);
            if (ok) begin
                exp_q.push_back(d);
                gap = $urandom_range(0, BIT);
            end else begin
                exp_ferr++;
                gap = BIT + $urandom_range(0, BIT);
            end
            idle(gap);
        end
        idle(BIT);
        check("rand_count", got_q.size(), exp_q.size());
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("rand_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("rand_ferr", ferr_cnt, exp_ferr);
        check("rand_overrun", ovr_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
